// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI mode-0 flash read responder (0x03 read; 0x0B fast read when
// SPI_FLASH_RESP_FAST_READ_EN is defined) over a word-organised, backdoor-loadable image.
module spi_flash_resp #(
  parameter int MEM_WORDS = 1024,
  parameter int AW = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          spi_sck,
  input  logic          spi_ss,
  input  logic          spi_mosi,
  output logic          spi_miso,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          busy,
  output logic [7:0]    err_cnt
);
  localparam int SW = (AW + 1 > 7) ? AW + 1 : 7;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  logic fast;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
`endif
  state_t        state;
  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   rdata;
  logic [AW+1:0] addr;
  logic [SW-1:0] sh;
  logic [4:0]    cnt;
  logic [7:0]    tx;
  logic          sck_q;
  logic          rise, fall;
  logic [7:0]    op, cur;
  assign rise = spi_sck & ~sck_q & ~spi_ss;
  assign fall = ~spi_sck & sck_q & ~spi_ss;
  assign op   = {sh[6:0], spi_mosi};
  assign cur  = rdata[{addr[1:0], 3'b000} +: 8];
  // Registered read tracks addr continuously, so the next byte is ready well before its first fall.
  always_ff @(posedge clock) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    rdata <= mem[addr[AW+1:2]];
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      spi_miso <= 1'b0;
      busy     <= 1'b0;
      err_cnt  <= '0;
      cnt      <= '0;
      sh       <= '0;
      addr     <= '0;
      tx       <= '0;
      sck_q    <= 1'b0;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
      fast     <= 1'b0;
`endif
    end else begin
      sck_q <= spi_sck;
      busy  <= ~spi_ss;
      if (spi_ss) begin
        state    <= IDLE;
        spi_miso <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= CMD;
            cnt   <= '0;
            sh    <= '0;
          end
          CMD: if (rise) begin
            sh  <= {sh[SW-2:0], spi_mosi};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd7) begin
              cnt <= '0;
              if (op == 8'h03) state <= ADDR;
`ifdef SPI_FLASH_RESP_FAST_READ_EN
              else if (op == 8'h0B) state <= ADDR;
`endif
              else begin
                state   <= IGNORE;
                err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
              end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
              fast <= (op == 8'h0B);
`endif
            end
          end
          ADDR: if (rise) begin
            sh  <= {sh[SW-2:0], spi_mosi};
            cnt <= cnt + 5'd1;
            if (cnt == 5'd23) begin
              cnt  <= '0;
              addr <= {sh[AW:0], spi_mosi};
`ifdef SPI_FLASH_RESP_FAST_READ_EN
              state <= fast ? DUMMY : DATA;
`else
              state <= DATA;
`endif
            end
          end
`ifdef SPI_FLASH_RESP_FAST_READ_EN
          DUMMY: if (rise) begin
            cnt <= cnt + 5'd1;
            if (cnt == 5'd7) begin
              cnt   <= '0;
              state <= DATA;
            end
          end
`endif
          DATA: if (fall) begin
            spi_miso <= (cnt[2:0] == 3'd0) ? cur[7] : tx[7];
            tx       <= (cnt[2:0] == 3'd0) ? {cur[6:0], 1'b0} : {tx[6:0], 1'b0};
            cnt      <= {2'b00, cnt[2:0] + 3'd1};
            if (cnt[2:0] == 3'd7) addr <= addr + (AW+2)'(1);
          end
          IGNORE: spi_miso <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
